// File: rtl/conv2d_seq.sv
// conv2d_seq: time-multiplexed fixed-point 2D convolution engine.
// One signed MAC per clock, Q-format rescale with saturation and optional
// ReLU. Results leave one element at a time on a valid/ready port, tagged
// with output channel, row and column.
module conv2d_seq #(
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int RELU         = 0,
  localparam int OUT_HEIGHT  = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1,
  localparam int OUT_WIDTH   = (IN_WIDTH + 2*PADDING - KERNEL_SIZE)/STRIDE + 1,
  localparam int TAPS        = IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE,
  localparam int CH_W        = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
  localparam int ROW_W       = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1,
  localparam int COL_W       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] input_tensor_flat,
  input  logic [OUT_CHANNELS*TAPS*DATA_WIDTH-1:0]            weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                 bias_flat,
  output logic                                               busy,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [DATA_WIDTH-1:0]                              out_data,
  output logic [CH_W-1:0]                                    out_ch,
  output logic [ROW_W-1:0]                                   out_row,
  output logic [COL_W-1:0]                                   out_col,
  output logic                                               out_last,
  output logic                                               done
);

  localparam int IC_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int K_W    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int IN_BITS = IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH;
  localparam int W_BITS  = OUT_CHANNELS*TAPS*DATA_WIDTH;
  localparam int B_BITS  = OUT_CHANNELS*DATA_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BIAS = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IC_W-1:0]  IC_LAST  = IC_W'(IN_CHANNELS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(KERNEL_SIZE - 1);
  localparam logic [CH_W-1:0]  OC_LAST  = CH_W'(OUT_CHANNELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Registered state and its next-state values
  logic [2:0]                    state_q, state_d;
  logic [IN_BITS-1:0]            in_q, in_d;
  logic [W_BITS-1:0]             w_q, w_d;
  logic [B_BITS-1:0]             b_q, b_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CH_W-1:0]               oc_q, oc_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [IC_W-1:0]               ic_q, ic_d;
  logic [K_W-1:0]                kh_q, kh_d;
  logic [K_W-1:0]                kw_q, kw_d;
  logic                          busy_q, busy_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;
  logic [ROW_W-1:0]              out_row_q, out_row_d;
  logic [COL_W-1:0]              out_col_q, out_col_d;
  logic                          out_last_q, out_last_d;
  logic                          done_q, done_d;

  // Datapath intermediates
  int                            ih_s, iw_s, pix_idx_s, w_idx_s;
  logic                          tap_in_s;
  logic signed [DATA_WIDTH-1:0]  pix_s, wt_s, bias_s;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]   prod_ext_s, bias_ext_s, shifted_s;
  logic [DATA_WIDTH-1:0]         res_s;
  logic                          last_pos_s;

  // Tap fetch, product, bias preload and output rescale/saturate/ReLU.
  always_comb begin
    ih_s      = int'(row_q)*STRIDE + int'(kh_q) - PADDING;
    iw_s      = int'(col_q)*STRIDE + int'(kw_q) - PADDING;
    tap_in_s  = (ih_s >= 0) && (ih_s < IN_HEIGHT) && (iw_s >= 0) && (iw_s < IN_WIDTH);
    pix_idx_s = int'(ic_q)*IN_HEIGHT*IN_WIDTH + ih_s*IN_WIDTH + iw_s;
    w_idx_s   = int'(oc_q)*TAPS + int'(ic_q)*KERNEL_SIZE*KERNEL_SIZE
              + int'(kh_q)*KERNEL_SIZE + int'(kw_q);
    // Padding taps contribute zero but still occupy their cycle.
    if (tap_in_s) begin
      pix_s = in_q[pix_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      pix_s = '0;
    end
    wt_s       = w_q[w_idx_s*DATA_WIDTH +: DATA_WIDTH];
    prod_s     = pix_s * wt_s;
    prod_ext_s = {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s};
    bias_s     = b_q[int'(oc_q)*DATA_WIDTH +: DATA_WIDTH];
    bias_ext_s = {{(ACC_WIDTH-DATA_WIDTH){bias_s[DATA_WIDTH-1]}}, bias_s} <<< FRAC_BITS;
    shifted_s  = acc_q >>> FRAC_BITS;
    if ((RELU != 0) && shifted_s[ACC_WIDTH-1]) begin
      res_s = '0;
    end else if (shifted_s > SAT_MAX) begin
      res_s = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted_s < SAT_MIN) begin
      res_s = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      res_s = shifted_s[DATA_WIDTH-1:0];
    end
    last_pos_s = (oc_q == OC_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Control FSM: snapshot, bias preload, tap walk, emit handshake, done.
  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    w_d         = w_q;
    b_d         = b_q;
    acc_d       = acc_q;
    oc_d        = oc_q;
    row_d       = row_q;
    col_d       = col_q;
    ic_d        = ic_q;
    kh_d        = kh_q;
    kw_d        = kw_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = input_tensor_flat;
          w_d     = weights_flat;
          b_d     = bias_flat;
          acc_d   = '0;
          oc_d    = '0;
          row_d   = '0;
          col_d   = '0;
          ic_d    = '0;
          kh_d    = '0;
          kw_d    = '0;
          busy_d  = 1'b1;
          state_d = S_BIAS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BIAS: begin
        acc_d   = bias_ext_s;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext_s;
        if (kw_q == K_LAST) begin
          kw_d = '0;
          if (kh_q == K_LAST) begin
            kh_d = '0;
            if (ic_q == IC_LAST) begin
              ic_d    = '0;
              state_d = S_EMIT;
            end else begin
              ic_d = ic_q + IC_W'(1);
            end
          end else begin
            kh_d = kh_q + K_W'(1);
          end
        end else begin
          kw_d = kw_q + K_W'(1);
        end
      end
      S_EMIT: begin
        if (!out_valid_q) begin
          // First EMIT cycle registers the result; it then holds until taken.
          out_valid_d = 1'b1;
          out_data_d  = res_s;
          out_ch_d    = oc_q;
          out_row_d   = row_q;
          out_col_d   = col_q;
          out_last_d  = last_pos_s;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_pos_s) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_BIAS;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d = '0;
                oc_d  = oc_q + CH_W'(1);
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand snapshot storage; contents are only meaningful during a job.
  always_ff @(posedge clk) begin
    in_q <= in_d;
    w_q  <= w_d;
    b_q  <= b_d;
  end

  // Control, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      oc_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ic_q        <= '0;
      kh_q        <= '0;
      kw_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      oc_q        <= oc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ic_q        <= ic_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv2d_seq.sv
// Self-checking bench for conv2d_seq: two configurations (default padded
// 3x3 Q8 engine, and a 2x2/stride-2 integer engine with ReLU) checked
// against a behavioural convolution model.
module tb_conv2d_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_s, ready_s, sel;
  int   checks = 0;
  int   failures = 0;

  // DUT A: default parameters
  logic a_start, a_busy, a_valid, a_last, a_done;
  logic [511:0] a_in;
  logic [575:0] a_w;
  logic [31:0]  a_b;
  logic [15:0]  a_data;
  logic [0:0]   a_ch;
  logic [1:0]   a_row, a_col;

  // DUT B: 1->1 channel, 4x4, K=2, S=2, P=0, integer, ReLU
  logic b_start, b_busy, b_valid, b_last, b_done;
  logic [255:0] b_in;
  logic [63:0]  b_w;
  logic [15:0]  b_b;
  logic [15:0]  b_data;
  logic [0:0]   b_ch, b_row, b_col;

  assign a_start = start_s & ~sel;
  assign b_start = start_s & sel;

  conv2d_seq dut_a (
    .clk(clk), .rst(rst), .start(a_start), .input_tensor_flat(a_in),
    .weights_flat(a_w), .bias_flat(a_b), .busy(a_busy), .out_valid(a_valid),
    .out_ready(ready_s), .out_data(a_data), .out_ch(a_ch), .out_row(a_row),
    .out_col(a_col), .out_last(a_last), .done(a_done));

  conv2d_seq #(
    .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
    .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0), .DATA_WIDTH(16),
    .FRAC_BITS(0), .ACC_WIDTH(40), .RELU(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .input_tensor_flat(b_in),
    .weights_flat(b_w), .bias_flat(b_b), .busy(b_busy), .out_valid(b_valid),
    .out_ready(ready_s), .out_data(b_data), .out_ch(b_ch), .out_row(b_row),
    .out_col(b_col), .out_last(b_last), .done(b_done));

  // Monitor view of whichever DUT is selected
  logic        m_busy, m_valid, m_last, m_done;
  logic [15:0] m_data;
  logic [0:0]  m_ch;
  logic [1:0]  m_row, m_col;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_last  = sel ? b_last  : a_last;
  assign m_done  = sel ? b_done  : a_done;
  assign m_data  = sel ? b_data  : a_data;
  assign m_ch    = sel ? b_ch    : a_ch;
  assign m_row   = sel ? {1'b0, b_row} : a_row;
  assign m_col   = sel ? {1'b0, b_col} : a_col;

  // Job configuration and operands (model view)
  int c_in, c_out, c_h, c_w, c_k, c_s, c_p, c_frac, c_relu, c_taps, c_oh, c_ow;
  int xin [32];
  int wt  [36];
  int bs  [2];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic use_dut(input logic which);
    sel = which;
    if (which) begin
      c_in = 1; c_out = 1; c_h = 4; c_w = 4; c_k = 2; c_s = 2; c_p = 0; c_frac = 0; c_relu = 1;
    end else begin
      c_in = 2; c_out = 2; c_h = 4; c_w = 4; c_k = 3; c_s = 1; c_p = 1; c_frac = 8; c_relu = 0;
    end
    c_taps = c_in*c_k*c_k;
    c_oh = (c_h + 2*c_p - c_k)/c_s + 1;
    c_ow = (c_w + 2*c_p - c_k)/c_s + 1;
    #1;
  endtask

  // Reference: plain convolution sum in wide integers, then Q rescale.
  function automatic longint model(input int oc, input int r, input int c);
    longint acc;
    int ih, iw;
    acc = longint'(bs[oc]) * (longint'(1) << c_frac);
    for (int ic = 0; ic < c_in; ic++)
      for (int kh = 0; kh < c_k; kh++)
        for (int kw = 0; kw < c_k; kw++) begin
          ih = r*c_s + kh - c_p;
          iw = c*c_s + kw - c_p;
          if (ih >= 0 && ih < c_h && iw >= 0 && iw < c_w)
            acc += longint'(xin[ic*c_h*c_w + ih*c_w + iw]) *
                   longint'(wt[oc*c_taps + ic*c_k*c_k + kh*c_k + kw]);
        end
    acc = acc >>> c_frac;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (c_relu != 0 && acc < 0) acc = 0;
    return acc;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 32; i++) xin[i] = lo + int'($urandom_range(hi - lo));
    for (int i = 0; i < 36; i++) wt[i]  = lo + int'($urandom_range(hi - lo));
    for (int i = 0; i < 2; i++)  bs[i]  = lo + int'($urandom_range(hi - lo));
  endtask

  task automatic fill_const(input int x, input int w, input int b);
    for (int i = 0; i < 32; i++) xin[i] = x;
    for (int i = 0; i < 36; i++) wt[i]  = w;
    for (int i = 0; i < 2; i++)  bs[i]  = b;
  endtask

  task automatic pack();
    logic [31:0] v;
    for (int i = 0; i < c_in*c_h*c_w; i++) begin
      v = xin[i];
      if (sel) b_in[i*16 +: 16] = v[15:0]; else a_in[i*16 +: 16] = v[15:0];
    end
    for (int i = 0; i < c_out*c_taps; i++) begin
      v = wt[i];
      if (sel) b_w[i*16 +: 16] = v[15:0]; else a_w[i*16 +: 16] = v[15:0];
    end
    for (int i = 0; i < c_out; i++) begin
      v = bs[i];
      if (sel) b_b[i*16 +: 16] = v[15:0]; else a_b[i*16 +: 16] = v[15:0];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {m_busy, m_valid, m_last, m_done, m_data, m_ch, m_row, m_col}, 0);
  endtask

  // One job: start, garble inputs and re-pulse start mid-job, then collect
  // every output checking latency, value, tags, last, optional stall/abort.
  task automatic run_job(input int stall_idx, input int abort_idx);
    int n, k, last_hs, waited, oc, r, c;
    logic signed [63:0] e;
    logic seen;
    n = c_out*c_oh*c_ow;
    pack();
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0; k = 0;
    chk("busy_after_start", m_busy, 1);
    a_in = {16{$urandom}}; a_w = {18{$urandom}}; a_b = $urandom;
    b_in = {8{$urandom}};  b_w = {2{$urandom}};  b_b = 16'($urandom);
    start_s = 1'b1;
    @(negedge clk); k++; start_s = 1'b0;
    last_hs = 0;
    ready_s = 1'b1;
    for (int idx = 0; idx < n; idx++) begin
      waited = 0;
      while (m_valid !== 1'b1 && waited < 400) begin
        @(negedge clk); k++; waited++;
      end
      chk("latency", k - last_hs, c_taps + 2);
      oc = idx/(c_oh*c_ow); r = (idx/c_ow) % c_oh; c = idx % c_ow;
      e = model(oc, r, c);
      chk("data", $signed(m_data), e);
      chk("tag_ch", m_ch, oc);
      chk("tag_row", m_row, r);
      chk("tag_col", m_col, c);
      chk("last", m_last, idx == n-1);
      if (idx == stall_idx) begin
        ready_s = 1'b0;
        repeat (5) begin
          @(negedge clk); k++;
          chk("stall_valid", m_valid, 1);
          chk("stall_data", $signed(m_data), e);
          chk("stall_tags", m_ch*100 + m_row*10 + m_col, oc*100 + r*10 + c);
        end
        ready_s = 1'b1;
      end
      @(negedge clk); k++; last_hs = k;
      chk("valid_drop", m_valid, 0);
      if (idx == abort_idx) begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_zero("abort_zero");
        seen = 1'b0;
        repeat (c_taps + 10) begin
          @(negedge clk);
          if (m_valid !== 1'b0 || m_busy !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_partial", seen, 0);
        return;
      end
      chk("done_pulse", m_done, idx == n-1);
      chk("busy_hold", m_busy, idx != n-1);
    end
    chk("done_time", k, n*(c_taps + 3) + ((stall_idx >= 0) ? 5 : 0));
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
  endtask

  initial begin
    rst = 1'b1; start_s = 1'b0; ready_s = 1'b1;
    a_in = '0; a_w = '0; a_b = '0; b_in = '0; b_w = '0; b_b = '0;
    use_dut(1'b0);
    repeat (3) @(negedge clk);
    chk_zero("reset_a");
    use_dut(1'b1);
    chk_zero("reset_b");
    rst = 1'b0;
    @(negedge clk);

    // Default engine: small values, then full range with backpressure
    use_dut(1'b0);
    fill(-512, 511);      run_job(-1, -1);
    fill(-32768, 32767);  run_job(1, -1);
    // Abort during MAC of the second output, then a fresh job
    fill(-512, 511);      run_job(-1, 0);
    fill(-2000, 2000);    run_job(-1, -1);
    fill_const(16'sh0180, 16'sh0200, 16'sh0040); run_job(-1, -1);

    // Stride-2 integer engine with ReLU
    use_dut(1'b1);
    fill_const(0, 1, 0);
    for (int i = 0; i < 16; i++) xin[i] = i + 1;
    run_job(-1, -1);
    fill_const(200, 200, 0);   run_job(-1, -1);
    fill_const(200, -200, 0);  run_job(-1, -1);
    fill(-300, 300);           run_job(2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
